// File: rtl/plic_target.sv
// Hart-side interrupt target: priority threshold gating of meip plus a
// two-register bus slave for threshold and claim/complete.
module plic_target #(
   parameter int PORTS          = 4,
   parameter int ID_WIDTH       = $clog2(PORTS),
   parameter int PRIORITY_WIDTH = $clog2(PORTS + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_int_pending,
   input  logic [ID_WIDTH-1:0]       in_int_id,
   input  logic [PRIORITY_WIDTH-1:0] in_int_priority,
   output logic [PORTS-1:0]          out_int_claim,
   output logic                      meip,
   input  logic                      req_valid,
   input  logic                      req_we,
   input  logic                      req_addr,
   input  logic [31:0]               req_wdata,
   output logic                      resp_valid,
   output logic [31:0]               resp_rdata
);

   typedef enum logic {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [PRIORITY_WIDTH-1:0] threshold_q, threshold_d;
   logic [ID_WIDTH-1:0]       svc_id_q, svc_id_d;
   logic                      meip_q, meip_d;
   logic [PORTS-1:0]          claim_q, claim_d;
   logic                      resp_valid_q, resp_valid_d;
   logic [31:0]               resp_rdata_q, resp_rdata_d;

   always_comb begin
      state_d      = state_q;
      threshold_d  = threshold_q;
      svc_id_d     = svc_id_q;
      claim_d      = '0;
      resp_valid_d = req_valid;
      resp_rdata_d = '0;

      if (req_valid) begin
         if (!req_addr) begin
            if (req_we) threshold_d = req_wdata[PRIORITY_WIDTH-1:0];
            else        resp_rdata_d = 32'(threshold_q);
         end else if (!req_we) begin
            // Claim is gated on the registered meip so software only wins what it was told about.
            if (state_q == IDLE && meip_q) begin
               state_d      = SERVICE;
               svc_id_d     = in_int_id;
               resp_rdata_d = 32'(in_int_id) + 32'd1;
               for (int unsigned i = 0; i < PORTS; i++)
                  claim_d[i] = (in_int_id == ID_WIDTH'(i));
            end
         end else if (state_q == SERVICE && req_wdata == 32'(svc_id_q) + 32'd1) begin
            state_d = IDLE;
         end
      end

      meip_d = (state_d == IDLE) && in_int_pending && (in_int_priority > threshold_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         threshold_q  <= '0;
         svc_id_q     <= '0;
         meip_q       <= 1'b0;
         claim_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         threshold_q  <= threshold_d;
         svc_id_q     <= svc_id_d;
         meip_q       <= meip_d;
         claim_q      <= claim_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   assign meip          = meip_q;
   assign out_int_claim = claim_q;
   assign resp_valid    = resp_valid_q;
   assign resp_rdata    = resp_rdata_q;

endmodule

// File: tb/tb_plic_target.sv
// Directed vector bench for plic_target: one table row per clock cycle,
// plus a hand-written claim-pulse sequence.
module tb_plic_target;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_int_pending;
   logic [1:0]  in_int_id;
   logic [2:0]  in_int_priority;
   logic [3:0]  out_int_claim;
   logic        meip;
   logic        req_valid;
   logic        req_we;
   logic        req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   plic_target #(.PORTS(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_int_pending  (in_int_pending),
      .in_int_id       (in_int_id),
      .in_int_priority (in_int_priority),
      .out_int_claim   (out_int_claim),
      .meip            (meip),
      .req_valid       (req_valid),
      .req_we          (req_we),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata)
   );

   typedef struct {
      logic        rst;
      logic        pend;
      logic [1:0]  id;
      logic [2:0]  pr;
      logic        v;
      logic        we;
      logic        a;
      logic [31:0] wd;
      logic        e_meip;
      logic [3:0]  e_claim;
      logic        e_rv;
      logic [31:0] e_rd;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic p, input logic [1:0] id,
                               input logic [2:0] pr, input logic v, input logic we,
                               input logic a, input logic [31:0] wd, input logic em,
                               input logic [3:0] ec, input logic erv, input logic [31:0] erd);
      vec_t t;
      t.rst = r; t.pend = p; t.id = id; t.pr = pr; t.v = v; t.we = we; t.a = a; t.wd = wd;
      t.e_meip = em; t.e_claim = ec; t.e_rv = erv; t.e_rd = erd;
      return t;
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got 0x%08h expected 0x%08h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic p, input logic [1:0] id, input logic [2:0] pr,
                        input logic v, input logic we, input logic a, input logic [31:0] wd);
      @(negedge clk);
      rst = r; in_int_pending = p; in_int_id = id; in_int_priority = pr;
      req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
   endtask

   initial begin
      int claim_cycles;
      logic [3:0] claim_seen;

      rst = 1'b1; in_int_pending = 1'b0; in_int_id = '0; in_int_priority = '0;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 1'b0; req_wdata = '0;

      //                rst pnd id pr  v we a  wdata          meip claim  rv rdata
      // reset
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,            0, 4'b0000, 0, 0));
      // basic claim of id 2
      vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0,            1, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 2, 3, 1, 0, 1, 0,            0, 4'b0100, 1, 3));
      // in service: masked, second claim empty, complete releases
      vecs.push_back(mk(0, 1, 1, 4, 0, 0, 0, 0,            0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 1, 4, 1, 0, 1, 0,            0, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 1, 4, 1, 1, 1, 3,            1, 4'b0000, 1, 0));
      // threshold gating (strict compare)
      vecs.push_back(mk(0, 1, 2, 3, 1, 1, 0, 3,            1, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0,            0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 2, 3, 1, 0, 1, 0,            0, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 2, 3, 1, 1, 0, 2,            0, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 2, 3, 0, 0, 0, 0,            1, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 2, 3, 1, 0, 0, 0,            1, 4'b0000, 1, 2));
      vecs.push_back(mk(0, 1, 2, 3, 1, 1, 0, 32'hFFFF_FFF9, 1, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 2, 3, 1, 0, 0, 0,            1, 4'b0000, 1, 1));
      // source id 0, wrong completes ignored
      vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0,            1, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 0, 1, 0,            0, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 0,            0, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 2,            0, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 1,            1, 4'b0000, 1, 0));
      // back-to-back claim then complete
      vecs.push_back(mk(0, 1, 0, 2, 1, 0, 1, 0,            0, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 1,            1, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0,            1, 4'b0000, 0, 0));
      // reset mid-service with a request in flight
      vecs.push_back(mk(0, 1, 0, 2, 1, 0, 1, 0,            0, 4'b0001, 1, 1));
      vecs.push_back(mk(1, 1, 0, 2, 1, 0, 1, 0,            0, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0,            1, 4'b0000, 0, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 0,            1, 4'b0000, 1, 0));
      vecs.push_back(mk(0, 1, 0, 2, 1, 0, 1, 0,            0, 4'b0001, 1, 1));
      vecs.push_back(mk(0, 1, 0, 2, 1, 1, 1, 1,            1, 4'b0000, 1, 0));
      // no pending source
      vecs.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0,            0, 4'b0000, 0, 0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].pend, vecs[i].id, vecs[i].pr,
               vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].wd);
         @(posedge clk);
         #1;
         check("meip",       i, 32'(meip),          32'(vecs[i].e_meip));
         check("claim",      i, 32'(out_int_claim), 32'(vecs[i].e_claim));
         check("resp_valid", i, 32'(resp_valid),    32'(vecs[i].e_rv));
         check("resp_rdata", i, resp_rdata,         vecs[i].e_rd);
      end

      // Claim pulse for id 3 must be one-hot and last exactly one cycle.
      drive(0, 1, 3, 1, 0, 0, 0, 0);
      for (int k = 0; k < 8 && meip !== 1'b1; k++) @(posedge clk);
      #1;
      check("meip_wait", 100, 32'(meip), 32'd1);
      drive(0, 1, 3, 1, 1, 0, 1, 0);
      @(posedge clk);
      #1;
      check("claim_rdata", 101, resp_rdata, 32'd4);
      drive(0, 1, 3, 1, 0, 0, 0, 0);
      claim_cycles = 0;
      claim_seen   = '0;
      if (out_int_claim != '0) begin
         claim_cycles++;
         claim_seen = out_int_claim;
      end
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         if (out_int_claim != '0) begin
            claim_cycles++;
            claim_seen |= out_int_claim;
         end
      end
      check("claim_cycles", 102, 32'(claim_cycles), 32'd1);
      check("claim_onehot", 103, 32'(claim_seen),   32'h8);
      check("meip_masked",  104, 32'(meip),         32'd0);
      drive(0, 1, 3, 1, 1, 1, 1, 4);
      @(posedge clk);
      #1;
      check("release_meip", 105, 32'(meip), 32'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
